// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and types for the 1-to-2 stream demux.
//                SEL_CH1/SEL_CH2 give the in_sel encoding; SKID_DEPTH is
//                the number of words each per-channel buffer can hold.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam logic SEL_CH1 = 1'b0;
  localparam logic SEL_CH2 = 1'b1;

  localparam int SKID_DEPTH = 2;

  // Occupancy counter must represent 0..SKID_DEPTH inclusive.
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : demux_skid_buf
//  Description : 2-entry skid buffer for one demux output channel. Accepts a
//                word on the s_* side when s_valid_i && s_ready_o, presents
//                the oldest word on the m_* side, and registers s_ready_o so
//                that no combinational path runs from m_ready_i to s_ready_o.
//  Ports       : clk_i, rst_i (async, active-high)
//                s_valid_i / s_ready_o / s_data_i  - upstream side
//                m_valid_o / m_ready_i / m_data_o  - downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_skid_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o
);

  skid_cnt_t         count_q, count_d;
  logic [DATA_W-1:0] head_q,  head_d;   // oldest word, drives m_data_o
  logic [DATA_W-1:0] tail_q,  tail_d;   // second word, valid only when count_q == 2
  logic              s_ready_q, s_ready_d;

  logic w_push;
  logic w_pop;

  assign w_push = s_valid_i && s_ready_q;
  assign w_pop  = (count_q != '0) && m_ready_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({w_push, w_pop})
      2'b10: begin
        if (count_q == '0) begin
          head_d = s_data_i;
        end else begin
          tail_d = s_data_i;
        end
        count_d = count_q + skid_cnt_t'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - skid_cnt_t'(1);
      end
      2'b11: begin
        // Occupancy unchanged. With one word held, the incoming word becomes
        // the new head directly; otherwise it queues behind the promoted tail.
        if (count_q == skid_cnt_t'(1)) begin
          head_d = s_data_i;
        end else begin
          head_d = tail_q;
          tail_d = s_data_i;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    // Ready reflects space after this cycle's update, so a full buffer
    // closes the input on the same edge that fills it.
    s_ready_d = (count_d < skid_cnt_t'(SKID_DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = (count_q != '0);
  assign m_data_o  = head_q;

endmodule : demux_skid_buf
`default_nettype wire

// File: rtl/demux1_2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_2_stream
//  Description : Registered 1-to-2 stream demultiplexer. Each accepted input
//                word is steered by in_sel into one of two skid buffers, so a
//                stalled consumer only blocks words addressed to it.
//  Ports       : sys_clk, sys_rst (async, active-high)
//                in_data / in_sel / in_valid / in_ready   - input stream
//                out1_* / out2_*                          - output channels
//                cnt1 / cnt2                              - per-channel push count
//  Options     : DEMUX_CNT_EN - when defined, cnt1/cnt2 count pushes to their
//                channel (wrapping); otherwise they are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1_2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out2_data,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2
);

  logic w_s_valid1, w_s_valid2;
  logic w_s_ready1, w_s_ready2;

  // Select decode: only the addressed buffer sees in_valid.
  assign w_s_valid1 = in_valid && (in_sel == SEL_CH1);
  assign w_s_valid2 = in_valid && (in_sel == SEL_CH2);

  // in_ready follows the addressed buffer; the other channel's state is
  // irrelevant, which is what keeps the two consumers independent.
  assign in_ready = (in_sel == SEL_CH2) ? w_s_ready2 : w_s_ready1;

  demux_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf_ch1 (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .s_valid_i (w_s_valid1),
    .s_ready_o (w_s_ready1),
    .s_data_i  (in_data),
    .m_valid_o (out1_valid),
    .m_ready_i (out1_ready),
    .m_data_o  (out1_data)
  );

  demux_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf_ch2 (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .s_valid_i (w_s_valid2),
    .s_ready_o (w_s_ready2),
    .s_data_i  (in_data),
    .m_valid_o (out2_valid),
    .m_ready_i (out2_ready),
    .m_data_o  (out2_data)
  );

`ifdef DEMUX_CNT_EN
  logic             w_push1, w_push2;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  assign w_push1 = w_s_valid1 && w_s_ready1;
  assign w_push2 = w_s_valid2 && w_s_ready2;

  // Natural binary wrap at 2^CNT_W-1 -> 0.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (w_push1) begin
      cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (w_push2) begin
      cnt2_d = cnt2_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`else
  assign cnt1 = '0;
  assign cnt2 = '0;
`endif

endmodule : demux1_2_stream
`default_nettype wire

// File: tb/tb_demux1_2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1_2_stream
//  Description : Directed self-checking bench for demux1_2_stream. Inputs
//                change and outputs are sampled around the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1_2_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
`ifdef DEMUX_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_sel   = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out1_data, out2_data;
  logic              out1_valid, out2_valid;
  logic              out1_ready = 1'b0;
  logic              out2_ready = 1'b0;
  logic [CNT_W-1:0]  cnt1, cnt2;

  int n_cmp = 0;
  int n_err = 0;

  demux1_2_stream #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  always #5 sys_clk = ~sys_clk;

  // Upstream stability rule: a stalled word keeps its data and select.
  logic              pv = 1'b0;
  logic              pr = 1'b0;
  logic              ps = 1'b0;
  logic [DATA_W-1:0] pd = '0;
  always @(posedge sys_clk) begin
    if (!sys_rst && pv && !pr && in_valid) begin
      n_cmp++;
      if (in_data !== pd || in_sel !== ps) begin
        n_err++;
        $display("FAIL upstream_stable: data=%h sel=%b required data=%h sel=%b", in_data, in_sel, pd, ps);
      end
    end
    pv <= in_valid;
    pr <= in_ready;
    pd <= in_data;
    ps <= in_sel;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    sys_rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
    out1_ready = 1'b1; out2_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    #1;
    n_cmp++; if (in_ready   !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL rst_out1_valid: got %b required 0", out1_valid); end
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL rst_out2_valid: got %b required 0", out2_valid); end
    n_cmp++; if (out1_data  !== 8'h00) begin n_err++; $display("FAIL rst_out1_data: got %h required 00", out1_data); end
    n_cmp++; if (out2_data  !== 8'h00) begin n_err++; $display("FAIL rst_out2_data: got %h required 00", out2_data); end
    n_cmp++; if (cnt1 !== 4'd0) begin n_err++; $display("FAIL rst_cnt1: got %h required 0", cnt1); end
    n_cmp++; if (cnt2 !== 4'd0) begin n_err++; $display("FAIL rst_cnt2: got %h required 0", cnt2); end
    @(negedge sys_clk); sys_rst = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL release_ready_first: got %b required 0", in_ready); end
    @(negedge sys_clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready_next: got %b required 1", in_ready); end
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL release_out1_early: got %b required 0", out1_valid); end
    @(negedge sys_clk); #1;
    n_cmp++; if (out1_valid !== 1'b1) begin n_err++; $display("FAIL release_out1_valid: got %b required 1", out1_valid); end
    n_cmp++; if (out1_data !== 8'h11) begin n_err++; $display("FAIL release_out1_data: got %h required 11", out1_data); end
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL release_out2_valid: got %b required 0", out2_valid); end
    in_valid = 1'b0;
    @(negedge sys_clk); #1;
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL release_out1_drain: got %b required 0", out1_valid); end
  endtask

  task automatic test_alternate;
    logic [DATA_W-1:0] w;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge sys_clk); #1;
      if (i > 1) begin
        w = 8'(i - 1);
        if (w[0]) begin
          n_cmp++; if (out1_valid !== 1'b1) begin n_err++; $display("FAIL alt_out1_valid w%0d: got %b required 1", w, out1_valid); end
          n_cmp++; if (out1_data  !== w)    begin n_err++; $display("FAIL alt_out1_data: got %h required %h", out1_data, w); end
          n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL alt_out2_idle w%0d: got %b required 0", w, out2_valid); end
        end else begin
          n_cmp++; if (out2_valid !== 1'b1) begin n_err++; $display("FAIL alt_out2_valid w%0d: got %b required 1", w, out2_valid); end
          n_cmp++; if (out2_data  !== w)    begin n_err++; $display("FAIL alt_out2_data: got %h required %h", out2_data, w); end
          n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL alt_out1_idle w%0d: got %b required 0", w, out1_valid); end
        end
      end
      if (i <= 8) begin
        in_valid = 1'b1; in_sel = (i % 2 == 0); in_data = 8'(i); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL alt_in_ready w%0d: got %b required 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge sys_clk); #1;
    n_cmp++; if ({out1_valid, out2_valid} !== 2'b00) begin n_err++; $display("FAIL alt_drain: got %b required 00", {out1_valid, out2_valid}); end
  endtask

  task automatic test_backpressure;
    out1_ready = 1'b1; out2_ready = 1'b0;
    @(negedge sys_clk); in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hA0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept_a0: got %b required 1", in_ready); end
    @(negedge sys_clk); in_data = 8'hA1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept_a1: got %b required 1", in_ready); end
    n_cmp++; if (out2_data !== 8'hA0) begin n_err++; $display("FAIL bp_head_a0: got %h required a0", out2_data); end
    @(negedge sys_clk); in_data = 8'hA2; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ch2: got %b required 0", in_ready); end
    @(negedge sys_clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_hold: got %b required 0", in_ready); end
    n_cmp++; if (out2_data !== 8'hA0) begin n_err++; $display("FAIL bp_head_hold: got %h required a0", out2_data); end
    @(negedge sys_clk); in_valid = 1'b0;
    @(negedge sys_clk); in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hB0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ch1_open: got %b required 1", in_ready); end
    @(negedge sys_clk); in_valid = 1'b0; out2_ready = 1'b1; #1;
    n_cmp++; if (out1_data !== 8'hB0 || out1_valid !== 1'b1) begin n_err++; $display("FAIL bp_out1_b0: got %b/%h required 1/b0", out1_valid, out1_data); end
    n_cmp++; if (out2_data !== 8'hA0 || out2_valid !== 1'b1) begin n_err++; $display("FAIL bp_out2_a0: got %b/%h required 1/a0", out2_valid, out2_data); end
    @(negedge sys_clk); #1;
    n_cmp++; if (out2_data !== 8'hA1 || out2_valid !== 1'b1) begin n_err++; $display("FAIL bp_out2_a1: got %b/%h required 1/a1", out2_valid, out2_data); end
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL bp_out1_drain: got %b required 0", out1_valid); end
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hA2; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen: got %b required 1", in_ready); end
    @(negedge sys_clk); in_valid = 1'b0; #1;
    n_cmp++; if (out2_data !== 8'hA2 || out2_valid !== 1'b1) begin n_err++; $display("FAIL bp_out2_a2: got %b/%h required 1/a2", out2_valid, out2_data); end
    @(negedge sys_clk); #1;
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL bp_out2_drain: got %b required 0", out2_valid); end
  endtask

  task automatic test_push_pop;
    out1_ready = 1'b1; out2_ready = 1'b1;
    @(negedge sys_clk); in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hC0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge sys_clk); #1;
      n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 8'(8'hC0 + k - 1)) begin
        n_err++; $display("FAIL pp_out1 k%0d: got %b/%h required 1/%h", k, out1_valid, out1_data, 8'(8'hC0 + k - 1));
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pp_in_ready k%0d: got %b required 1", k, in_ready); end
      in_data = 8'(8'hC0 + k);
    end
    @(negedge sys_clk); in_valid = 1'b0; #1;
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 8'hCA) begin n_err++; $display("FAIL pp_last: got %b/%h required 1/ca", out1_valid, out1_data); end
    @(negedge sys_clk); #1;
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL pp_drain: got %b required 0", out1_valid); end
  endtask

  task automatic test_reset_mid;
    logic [DATA_W-1:0] words [4] = '{8'hD0, 8'hD1, 8'hE0, 8'hE1};
    out1_ready = 1'b0; out2_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk); in_valid = 1'b1; in_sel = (i >= 2); in_data = words[i]; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_fill %0d: got %b required 1", i, in_ready); end
    end
    @(negedge sys_clk); in_valid = 1'b0; in_sel = 1'b0; #1;
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 8'hD0) begin n_err++; $display("FAIL rm_out1_full: got %b/%h required 1/d0", out1_valid, out1_data); end
    n_cmp++; if (out2_valid !== 1'b1 || out2_data !== 8'hE0) begin n_err++; $display("FAIL rm_out2_full: got %b/%h required 1/e0", out2_valid, out2_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready_ch1: got %b required 0", in_ready); end
    in_sel = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready_ch2: got %b required 0", in_ready); end
    sys_rst = 1'b1; #1;
    n_cmp++; if ({out1_valid, out2_valid} !== 2'b00) begin n_err++; $display("FAIL rm_async_valid: got %b required 00", {out1_valid, out2_valid}); end
    n_cmp++; if (out1_data !== 8'h00 || out2_data !== 8'h00) begin n_err++; $display("FAIL rm_async_data: got %h/%h required 00/00", out1_data, out2_data); end
    n_cmp++; if (cnt1 !== 4'd0 || cnt2 !== 4'd0) begin n_err++; $display("FAIL rm_async_cnt: got %h/%h required 0/0", cnt1, cnt2); end
    @(negedge sys_clk); sys_rst = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk); #1;
      n_cmp++; if ({out1_valid, out2_valid} !== 2'b00) begin n_err++; $display("FAIL rm_stale %0d: got %b required 00", i, {out1_valid, out2_valid}); end
    end
  endtask

  task automatic test_counter;
    logic [CNT_W-1:0] e1;
    out1_ready = 1'b1; out2_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      in_data = 8'(k);
      @(negedge sys_clk); #1;
      e1 = CNT_ON ? 4'(k) : 4'd0;
      n_cmp++; if (cnt1 !== e1) begin n_err++; $display("FAIL cnt1 k%0d: got %h required %h", k, cnt1, e1); end
      n_cmp++; if (cnt2 !== 4'd0) begin n_err++; $display("FAIL cnt2 k%0d: got %h required 0", k, cnt2); end
      n_cmp++; if (out1_data !== 8'(k)) begin n_err++; $display("FAIL cnt_data k%0d: got %h required %h", k, out1_data, 8'(k)); end
    end
    in_valid = 1'b0;
    @(negedge sys_clk); #1;
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL cnt_drain: got %b required 0", out1_valid); end
  endtask

  initial begin
    sys_rst = 1'b1;
    test_reset();
    test_alternate();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux1_2_stream
`default_nettype wire
